us_arp_tx: RTL and testbench
============================

# us_arp_tx

ARP frame transmitter for the 10 Gbps UDP stack, sitting between the ARP table/ARP receive path and the MAC TX arbiter. It accepts two kinds of job through req/ack handshakes. An ARP request job comes from the ARP table and resolves `dst_ip_addr`. An ARP reply job comes from the ARP receive parser when a peer asks for our IP. For each job the block emits one complete 60-byte Ethernet/ARP frame, zero-padded, on a 64-bit AXI-Stream master. All job fields are latched at acceptance, so upstream values may change freely afterwards.

## Interface
- `GAP_CYCLES`, default 4: idle cycles forced after each frame's last beat before the next job is accepted (0 allowed).

- `clk`  in  1  single clock for all logic.
- `rstn`  in  1  reset, asynchronous, active-low.
- `local_mac_addr`  in  48  our MAC, sampled at job acceptance.
- `local_ip_addr`  in  32  our IP, sampled at job acceptance.
- `arp_request_req`  in  1  request job pending; held high until ack.
- `dst_ip_addr`  in  32  target IP for a request job.
- `arp_request_ack`  out  1  one-cycle pulse: request job accepted.
- `arp_reply_req`  in  1  reply job pending; held high until ack.
- `reply_dst_mac`  in  48  requester MAC for a reply job.
- `reply_dst_ip`  in  32  requester IP for a reply job.
- `arp_reply_ack`  out  1  one-cycle pulse: reply job accepted.
- `m_axis_tdata`  out  64  frame data; byte k of the beat is on bits [8k+7:8k], first wire byte is at [7:0].
- `m_axis_tkeep`  out  8  byte enables.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tlast`  out  1  last beat of frame.
- `m_axis_tready`  in  1  downstream ready.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, SEND, GAP.
- **IDLE**
  - If `arp_reply_req` is high, accept a reply job. Reply has priority.
  - Otherwise, if `arp_request_req` is high, accept a request job.
  - On acceptance: latch all job fields and the local addresses, pulse the matching ack for one cycle, clear the beat counter, go to SEND.
- **SEND**
  - Present beats 0..7.
  - The beat counter (3 bit) advances only on `tvalid & tready`.
  - A handshake on beat 7 goes to GAP, or straight to IDLE if `GAP_CYCLES` = 0.
- **GAP**
  - Count `GAP_CYCLES` cycles, then go to IDLE.
  - Req inputs are ignored in SEND and GAP. The ack is issued once per accepted job, and a req still high one cycle after its ack is not re-accepted.
- **Frame bytes** (multi-byte fields MSB first):
  - 0-5: DA. Request: ff:ff:ff:ff:ff:ff. Reply: `reply_dst_mac`.
  - 6-11: SA = local MAC.
  - 12-13: 08 06.
  - 14-15: 00 01.
  - 16-17: 08 00.
  - 18: 06.
  - 19: 04.
  - 20-21: OPER. Request: 00 01. Reply: 00 02.
  - 22-27: local MAC.
  - 28-31: local IP.
  - 32-37: THA. Request: all zero. Reply: `reply_dst_mac`.
  - 38-41: TPA. Request: `dst_ip_addr`. Reply: `reply_dst_ip`.
  - 42-59: zero.
- **Beat framing**
  - Beats 0-6: `tkeep` = 8'hFF.
  - Beat 7: `tkeep` = 8'h0F, `tlast` = 1, unused bytes are 0.
  - No FCS; the MAC appends it.

## Timing
- **Reset values:**
  - All outputs are 0, including `tkeep` = 0.
  - FSM is in IDLE, counters are 0.
- **Latency**
  - A req sampled high at clock edge N gives ack high during cycle N+1 and `tvalid` high with beat 0 from cycle N+1.
  - The minimum frame length is 8 cycles, with `tready` held high.
- **AXI rules**
  - While `tvalid & ~tready`, `tdata`, `tkeep` and `tlast` stay stable.
  - Once asserted, `tvalid` never drops before its beat's handshake.
  - `tvalid`, `tlast` and `tkeep` are 0 outside SEND.
- **Back-to-back jobs:** the next acceptance happens no earlier than `GAP_CYCLES`+1 cycles after the beat 7 handshake.
- **Simultaneous reqs:** the reply job is served first. The request job stays pending and is accepted in the first IDLE cycle after the reply frame's gap.
- **Reset mid-frame**
  - `tvalid` deasserts asynchronously and the frame is abandoned with no `tlast`.
  - After `rstn` rises, a still-pending req is re-accepted and its frame restarts at beat 0.
- **Local address changes:** changes to `local_*` inputs during SEND do not affect the frame in flight.

## Test plan
- **Request frame.**
  - Stimulus: local 00:0a:35:01:02:03 / 192.168.1.10, `dst_ip_addr` = 192.168.1.100, `tready` = 1, request req raised.
  - Required response: one-cycle `arp_request_ack`; 8 beats.
  - Beat 0 `tdata` = 64'h0A00FFFFFFFFFFFF.
  - Beat 1 `tdata` = 64'h0100060803020135.
  - Beat 7: `tkeep` = 8'h0F, `tlast` = 1.
- **Reply frame.**
  - Stimulus: same local addresses, `reply_dst_mac` = 11:22:33:44:55:66, `reply_dst_ip` = 192.168.1.100.
  - Required response: beat 0 = 64'h0A00665544332211, beat 2 = 64'h0A00020004060008, TPA bytes = c0 a8 01 64.
- **Simultaneous reqs.**
  - Stimulus: reply and request req raised in the same cycle.
  - Required response: reply ack first, then the full reply frame; request ack exactly `GAP_CYCLES`+1 cycles after the reply's `tlast` handshake.
- **Backpressure.**
  - Stimulus: hold `tready` = 0 for 10 cycles at beat 3, then toggle it randomly.
  - Required response: beat 3 held stable; exactly 8 handshakes, with no duplicated or skipped beat.
- **Reset mid-frame.**
  - Stimulus: assert `rstn` = 0 during beat 4 while req stays high.
  - Required response: `tvalid` = 0 immediately; after release, a new ack and a complete frame from beat 0.
- **Gap and re-accept.**
  - Stimulus: request req kept high for 3 cycles after its ack, with `GAP_CYCLES` = 4.
  - Required response: only one ack and one frame; `busy` high for 8+4 cycles with `tready` = 1.

Source files
------------

// File: rtl/us_arp_tx.sv
// ARP frame transmitter: turns request/reply jobs into one
// 60-byte Ethernet/ARP frame on a 64-bit AXI-Stream master.
module us_arp_tx #(
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [47:0] local_mac_addr,
  input  logic [31:0] local_ip_addr,
  input  logic        arp_request_req,
  input  logic [31:0] dst_ip_addr,
  output logic        arp_request_ack,
  input  logic        arp_reply_req,
  input  logic [47:0] reply_dst_mac,
  input  logic [31:0] reply_dst_ip,
  output logic        arp_reply_ack,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e          state_q, state_d;
  logic [2:0]      beat_q, beat_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            rply_q, rply_d;
  logic [47:0]     mac_q, mac_d;
  logic [31:0]     ip_q, ip_d;
  logic [47:0]     dmac_q, dmac_d;
  logic [31:0]     tip_q, tip_d;
  logic            qack_q, qack_d;
  logic            pack_q, pack_d;

  logic            send;
  logic            hs;
  logic [511:0]    frame;
  logic [47:0]     da;
  logic [47:0]     tha;

  assign send = (state_q == SEND);
  assign hs   = send & m_axis_tready;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    rply_d  = rply_q;
    mac_d   = mac_q;
    ip_d    = ip_q;
    dmac_d  = dmac_q;
    tip_d   = tip_q;
    qack_d  = 1'b0;
    pack_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arp_reply_req) begin
          pack_d  = 1'b1;
          rply_d  = 1'b1;
          dmac_d  = reply_dst_mac;
          tip_d   = reply_dst_ip;
          mac_d   = local_mac_addr;
          ip_d    = local_ip_addr;
          beat_d  = 3'd0;
          state_d = SEND;
        end else if (arp_request_req) begin
          qack_d  = 1'b1;
          rply_d  = 1'b0;
          dmac_d  = 48'h0;
          tip_d   = dst_ip_addr;
          mac_d   = local_mac_addr;
          ip_d    = local_ip_addr;
          beat_d  = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      beat_q  <= 3'd0;
      gap_q   <= '0;
      rply_q  <= 1'b0;
      mac_q   <= 48'h0;
      ip_q    <= 32'h0;
      dmac_q  <= 48'h0;
      tip_q   <= 32'h0;
      qack_q  <= 1'b0;
      pack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      rply_q  <= rply_d;
      mac_q   <= mac_d;
      ip_q    <= ip_d;
      dmac_q  <= dmac_d;
      tip_q   <= tip_d;
      qack_q  <= qack_d;
      pack_q  <= pack_d;
    end
  end

  // Wire byte i lives at frame[8i+:8]; bytes 42..63 stay zero.
  always_comb begin
    frame = '0;
    da    = rply_q ? dmac_q : 48'hFFFF_FFFF_FFFF;
    tha   = rply_q ? dmac_q : 48'h0;
    for (int i = 0; i < 6; i++) begin
      frame[8*i+:8]      = da[8*(5-i)+:8];
      frame[8*(6+i)+:8]  = mac_q[8*(5-i)+:8];
      frame[8*(22+i)+:8] = mac_q[8*(5-i)+:8];
      frame[8*(32+i)+:8] = tha[8*(5-i)+:8];
    end
    frame[8*12+:8] = 8'h08;
    frame[8*13+:8] = 8'h06;
    frame[8*15+:8] = 8'h01;
    frame[8*16+:8] = 8'h08;
    frame[8*18+:8] = 8'h06;
    frame[8*19+:8] = 8'h04;
    frame[8*21+:8] = rply_q ? 8'h02 : 8'h01;
    for (int i = 0; i < 4; i++) begin
      frame[8*(28+i)+:8] = ip_q[8*(3-i)+:8];
      frame[8*(38+i)+:8] = tip_q[8*(3-i)+:8];
    end
  end

  assign m_axis_tvalid = send;
  assign m_axis_tlast  = send & (beat_q == 3'd7);
  assign m_axis_tkeep  = !send ? 8'h00 :
                         (beat_q == 3'd7) ? 8'h0F : 8'hFF;
  assign m_axis_tdata  = send ? frame[{beat_q, 6'd0}+:64] : 64'h0;
  assign busy            = (state_q != IDLE);
  assign arp_request_ack = qack_q;
  assign arp_reply_ack   = pack_q;

endmodule

// File: tb/tb_us_arp_tx.sv
// Scoreboard bench for us_arp_tx: expected beats queued at
// job launch, compared as the stream presents them.
module tb_us_arp_tx;

  localparam int GAP = 4;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk;
  logic        rstn;
  logic [47:0] local_mac_addr;
  logic [31:0] local_ip_addr;
  logic        arp_request_req;
  logic [31:0] dst_ip_addr;
  logic        arp_request_ack;
  logic        arp_reply_req;
  logic [47:0] reply_dst_mac;
  logic [31:0] reply_dst_ip;
  logic        arp_reply_ack;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        busy;

  us_arp_tx #(.GAP_CYCLES(GAP)) dut (
    .clk(clk),
    .rstn(rstn),
    .local_mac_addr(local_mac_addr),
    .local_ip_addr(local_ip_addr),
    .arp_request_req(arp_request_req),
    .dst_ip_addr(dst_ip_addr),
    .arp_request_ack(arp_request_ack),
    .arp_reply_req(arp_reply_req),
    .reply_dst_mac(reply_dst_mac),
    .reply_dst_ip(reply_dst_ip),
    .arp_reply_ack(arp_reply_ack),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .busy(busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          hs_cnt = 0;
  int          frames = 0;
  int          ack_cnt = 0;
  int          last_cyc = 0;
  bit          stall = 0;
  beat_t       exp_q[$];
  logic [63:0] obs[8];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [479:0] wire_frame(
    input bit rply, input logic [47:0] mac, input logic [31:0] ip,
    input logic [47:0] dmac, input logic [31:0] tip);
    logic [47:0] da;
    logic [47:0] tha;
    logic [7:0]  op;
    da  = rply ? dmac : 48'hFFFF_FFFF_FFFF;
    tha = rply ? dmac : 48'h0;
    op  = rply ? 8'h02 : 8'h01;
    return {da, mac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
            8'h00, op, mac, ip, tha, tip, 144'h0};
  endfunction

  task automatic push_job(input bit rply, input logic [47:0] mac,
                          input logic [31:0] ip,
                          input logic [47:0] dmac,
                          input logic [31:0] tip);
    logic [479:0] w;
    beat_t        e;
    int           idx;
    w = wire_frame(rply, mac, ip, dmac, tip);
    for (int b = 0; b < 8; b++) begin
      e.d = 64'h0;
      for (int k = 0; k < 8; k++) begin
        idx = 8 * b + k;
        if (idx < 60) e.d[8*k+:8] = w[479-8*idx-:8];
      end
      e.k = (b == 7) ? 8'h0F : 8'hFF;
      e.l = (b == 7);
      exp_q.push_back(e);
    end
    hs_cnt = 0;
  endtask

  task automatic wait_ack(input bit rep, output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (rep ? arp_reply_ack : arp_request_ack) ok = 1;
    end
    chk("ack_seen", 64'(ok), 64'd1);
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 300 && frames < n; i++) @(negedge clk);
    chk("frame_done", 64'(frames >= n), 64'd1);
  endtask

  task automatic settle();
    repeat (GAP + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      stall = 0;
    end else begin
      if (arp_request_ack || arp_reply_ack) ack_cnt++;
      if (stall) chk("valid_hold", 64'(m_axis_tvalid), 64'd1);
      if (m_axis_tvalid) begin
        chk("sb_has_beat", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          chk("tdata", m_axis_tdata, exp_q[0].d);
          chk("tkeep", 64'(m_axis_tkeep), 64'(exp_q[0].k));
          chk("tlast", 64'(m_axis_tlast), 64'(exp_q[0].l));
          if (m_axis_tready) begin
            void'(exp_q.pop_front());
            if (hs_cnt < 8) obs[hs_cnt] = m_axis_tdata;
            hs_cnt++;
            if (m_axis_tlast) begin
              frames++;
              last_cyc = cyc + 1;
            end
          end
        end
      end else begin
        chk("idle_tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("idle_tlast", 64'(m_axis_tlast), 64'd0);
      end
      stall = m_axis_tvalid && !m_axis_tready;
    end
  end

  initial begin
    bit ok;
    int f0;
    int a0;
    int bc;
    rstn = 0;
    local_mac_addr = 48'h000A_3501_0203;
    local_ip_addr = 32'hC0A8_010A;
    arp_request_req = 0;
    dst_ip_addr = 32'hC0A8_0164;
    arp_reply_req = 0;
    reply_dst_mac = 48'h1122_3344_5566;
    reply_dst_ip = 32'hC0A8_0164;
    m_axis_tready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_acks", 64'({arp_request_ack, arp_reply_ack}), 64'd0);
    rstn = 1;
    repeat (2) @(posedge clk);
    #1;

    // request frame
    f0 = frames;
    arp_request_req = 1;
    push_job(0, local_mac_addr, local_ip_addr, 48'h0, dst_ip_addr);
    wait_ack(0, ok);
    arp_request_req = 0;
    local_mac_addr = 48'hDEAD_BEEF_0000;
    @(negedge clk);
    chk("req_ack_pulse", 64'(arp_request_ack), 64'd0);
    wait_frames(f0 + 1);
    chk("req_beat0", obs[0], 64'h0A00FFFFFFFFFFFF);
    chk("req_beat1", obs[1], 64'h0100060803020135);
    chk("req_beats", 64'(hs_cnt), 64'd8);
    local_mac_addr = 48'h000A_3501_0203;
    settle();

    // reply frame
    f0 = frames;
    arp_reply_req = 1;
    push_job(1, local_mac_addr, local_ip_addr, reply_dst_mac,
             reply_dst_ip);
    wait_ack(1, ok);
    arp_reply_req = 0;
    reply_dst_ip = 32'h0;
    wait_frames(f0 + 1);
    chk("rep_beat0", obs[0], 64'h0A00665544332211);
    chk("rep_beat2", obs[2], 64'h0A00020004060008);
    chk("rep_tpa_hi", 64'(obs[4][63:48]), 64'hA8C0);
    chk("rep_tpa_lo", 64'(obs[5][15:0]), 64'h6401);
    reply_dst_ip = 32'hC0A8_0164;
    settle();

    // simultaneous reqs
    f0 = frames;
    arp_reply_req = 1;
    arp_request_req = 1;
    push_job(1, local_mac_addr, local_ip_addr, reply_dst_mac,
             reply_dst_ip);
    push_job(0, local_mac_addr, local_ip_addr, 48'h0, dst_ip_addr);
    wait_ack(1, ok);
    chk("sim_req_wait", 64'(arp_request_ack), 64'd0);
    arp_reply_req = 0;
    wait_ack(0, ok);
    arp_request_req = 0;
    chk("sim_frame1", 64'(frames - f0), 64'd1);
    chk("sim_gap", 64'(cyc - last_cyc), 64'(GAP + 1));
    wait_frames(f0 + 2);
    settle();

    // backpressure
    f0 = frames;
    arp_request_req = 1;
    push_job(0, local_mac_addr, local_ip_addr, 48'h0, dst_ip_addr);
    wait_ack(0, ok);
    arp_request_req = 0;
    for (int i = 0; i < 40 && hs_cnt != 3; i++) begin
      @(posedge clk);
      #1;
    end
    m_axis_tready = 0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 300 && hs_cnt < 8; i++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    m_axis_tready = 1;
    wait_frames(f0 + 1);
    chk("bp_beats", 64'(hs_cnt), 64'd8);
    settle();

    // reset mid-frame
    f0 = frames;
    arp_request_req = 1;
    push_job(0, local_mac_addr, local_ip_addr, 48'h0, dst_ip_addr);
    for (int i = 0; i < 40 && hs_cnt != 4; i++) begin
      @(posedge clk);
      #1;
    end
    rstn = 0;
    #1;
    chk("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_mid_tlast", 64'(m_axis_tlast), 64'd0);
    exp_q.delete();
    push_job(0, local_mac_addr, local_ip_addr, 48'h0, dst_ip_addr);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1;
    wait_ack(0, ok);
    arp_request_req = 0;
    wait_frames(f0 + 1);
    chk("rst_restart_beats", 64'(hs_cnt), 64'd8);
    settle();

    // gap and re-accept
    f0 = frames;
    a0 = ack_cnt;
    arp_request_req = 1;
    push_job(0, local_mac_addr, local_ip_addr, 48'h0, dst_ip_addr);
    wait_ack(0, ok);
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        arp_request_req = 0;
      end
    join_none
    bc = busy ? 1 : 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
    end
    chk("gap_busy", 64'(bc), 64'(8 + GAP));
    settle();
    chk("gap_acks", 64'(ack_cnt - a0), 64'd1);
    chk("gap_frames", 64'(frames - f0), 64'd1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
